// File: rtl/multicycle_fsm.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : multicycle_fsm
// Purpose  : Main control state machine of the multicycle RV32I core. It
//            sequences fetch, decode, execute, memory access and write-back
//            over several cycles, sharing one ALU, one register file and one
//            unified memory port. It stalls on the memory ready handshake.
// Ports    : clk          rising-edge clock
//            rst_n        synchronous active-low reset
//            op[6:0]      opcode from the instruction register (DECODE onward)
//            zero         ALU zero flag (branch decision)
//            mem_ready    memory completes the current access this cycle
//            mem_req      memory access request
//            mem_write    access is a store (qualified by mem_req)
//            adr_src      memory address select: 0 = PC, 1 = ALUOut
//            ir_write     load instruction register and OldPC
//            pc_write     load PC from the result bus
//            reg_write    register file write enable
//            alu_src_a    00 = PC, 01 = OldPC, 10 = rs1 data
//            alu_src_b    00 = rs2 data, 01 = immediate, 10 = constant 4
//            result_src   00 = ALUOut, 01 = memory data, 10 = ALU result
//            alu_op       00 = add, 01 = subtract, 10 = funct-decoded
//            illegal_instr one-cycle pulse in DECODE for unsupported opcodes
//            state[3:0]   current state, debug only
// Config   : MULTICYCLE_JAL_EN - when defined, adds the JAL state and the
//            1101111 decode; otherwise jal decodes as illegal.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_fsm (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic [1:0] alu_op,
    output logic       illegal_instr,
    output logic [3:0] state
);

    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] c_OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    state_t r_state;
    logic   w_op_legal;

    // Opcode legality; shared by next-state decode and the illegal pulse.
    always_comb begin
        w_op_legal = 1'b0;
        case (op)
            c_OP_LOAD, c_OP_STORE, c_OP_RTYPE, c_OP_ITYPE, c_OP_BRANCH: w_op_legal = 1'b1;
`ifdef MULTICYCLE_JAL_EN
            c_OP_JAL: w_op_legal = 1'b1;
`endif
            default: w_op_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            case (r_state)
                S_FETCH:    if (mem_ready) r_state <= S_DECODE;
                S_DECODE: begin
                    case (op)
                        c_OP_LOAD, c_OP_STORE: r_state <= S_MEMADR;
                        c_OP_RTYPE:            r_state <= S_EXECUTER;
                        c_OP_ITYPE:            r_state <= S_EXECUTEI;
                        c_OP_BRANCH:           r_state <= S_BEQ;
`ifdef MULTICYCLE_JAL_EN
                        c_OP_JAL:              r_state <= S_JAL;
`endif
                        default:               r_state <= S_FETCH;
                    endcase
                end
                // op[5] separates store (0100011) from load (0000011)
                S_MEMADR:   r_state <= op[5] ? S_MEMWRITE : S_MEMREAD;
                S_MEMREAD:  if (mem_ready) r_state <= S_MEMWB;
                S_MEMWB:    r_state <= S_FETCH;
                S_MEMWRITE: if (mem_ready) r_state <= S_FETCH;
                S_EXECUTER: r_state <= S_ALUWB;
                S_EXECUTEI: r_state <= S_ALUWB;
                S_ALUWB:    r_state <= S_FETCH;
                S_BEQ:      r_state <= S_FETCH;
`ifdef MULTICYCLE_JAL_EN
                S_JAL:      r_state <= S_ALUWB;
`endif
                default:    r_state <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        mem_req       = 1'b0;
        mem_write     = 1'b0;
        adr_src       = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        result_src    = 2'b00;
        alu_op        = 2'b00;
        illegal_instr = 1'b0;
        case (r_state)
            S_FETCH: begin
                // PC + 4 computed in the same cycle the instruction returns
                mem_req    = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
            end
            S_DECODE: begin
                // Branch/jump target precomputed into ALUOut
                alu_src_a     = 2'b01;
                alu_src_b     = 2'b01;
                illegal_instr = ~w_op_legal;
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                adr_src   = 1'b1;
            end
            S_EXECUTER: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
            end
            S_EXECUTEI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
            end
            S_ALUWB: reg_write = 1'b1;
            S_BEQ: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                pc_write  = zero;
            end
`ifdef MULTICYCLE_JAL_EN
            S_JAL: begin
                // Return address OldPC + 4; jump target already in ALUOut
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
            end
`endif
            default: ;
        endcase
        // While in reset: quiet all side effects, present FETCH selects
        if (!rst_n) begin
            mem_req       = 1'b0;
            mem_write     = 1'b0;
            ir_write      = 1'b0;
            pc_write      = 1'b0;
            reg_write     = 1'b0;
            illegal_instr = 1'b0;
            adr_src       = 1'b0;
            alu_src_a     = 2'b00;
            alu_src_b     = 2'b10;
            result_src    = 2'b10;
            alu_op        = 2'b00;
        end
    end

    assign state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_fsm.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_fsm
// Purpose  : Self-checking bench for multicycle_fsm. Each instruction is
//            expanded into its per-cycle expected control vector; a compare
//            process checks the DUT every cycle. Literal state sequences and
//            pulse counts pin the expectation builder itself.
// Config   : honours MULTICYCLE_JAL_EN like the design.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_fsm;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] op = 7'b0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic [1:0] alu_src_a, alu_src_b, result_src, alu_op;
    logic       illegal_instr;
    logic [3:0] state;

    multicycle_fsm dut (
        .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src),
        .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .result_src(result_src),
        .alu_op(alu_op), .illegal_instr(illegal_instr), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic       mreq, mwr, adr, irw, pcw, rw;
        logic [1:0] sa, sb, rs, aop;
        logic       ill;
    } exp_t;

    exp_t exp_q[$];
    bit   chk_q[$];
    int   checks = 0;
    int   errors = 0;
    logic [63:0] log_word = 64'd0;
    int   log_len = 0;
    int   ill_cnt = 0;

    function automatic exp_t mk(input logic [3:0] st, input logic mreq, mwr, adr, irw, pcw, rw,
                                input logic [1:0] sa, sb, rs, aop, input logic ill);
        exp_t e;
        e.st = st; e.mreq = mreq; e.mwr = mwr; e.adr = adr; e.irw = irw; e.pcw = pcw;
        e.rw = rw; e.sa = sa; e.sb = sb; e.rs = rs; e.aop = aop; e.ill = ill;
        return e;
    endfunction

    // Reset cycle: FETCH selects with every side-effect output low.
    function automatic exp_t e_reset(input logic [3:0] st);
        return mk(st, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b10, 2'b00, 0);
    endfunction

    // Compare process: one expected vector per cycle, checked mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e, a;
            bit   c;
            e = exp_q.pop_front();
            c = chk_q.pop_front();
            a = mk(state, mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                   alu_src_a, alu_src_b, result_src, alu_op, illegal_instr);
            if (c) begin
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL cycle_cmp t=%0t actual=%h required=%h (st,mreq,mwr,adr,irw,pcw,rw,sa,sb,rs,aop,ill)",
                             $time, a, e);
                end
            end
            log_word = {log_word[59:0], state};
            log_len++;
            if (illegal_instr === 1'b1) ill_cnt++;
        end
    end

    // One clock cycle of stimulus plus its expectation.
    task automatic cyc(input logic rdy, input logic z, input logic rn, input exp_t e, input bit chk);
        mem_ready = rdy;
        zero      = z;
        rst_n     = rn;
        exp_q.push_back(e);
        chk_q.push_back(chk);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log;
        log_word = 64'd0;
        log_len  = 0;
        ill_cnt  = 0;
    endtask

    task automatic check_log(input string name, input logic [63:0] w, input int len);
        checks++;
        if (log_word !== w || log_len != len) begin
            errors++;
            $display("FAIL %s states=%h len=%0d required states=%h len=%0d", name, log_word, log_len, w, len);
        end
    endtask

    task automatic check_ill(input string name, input int n);
        checks++;
        if (ill_cnt != n) begin
            errors++;
            $display("FAIL %s illegal_pulses=%0d required=%0d", name, ill_cnt, n);
        end
    endtask

    // Fetch with fs wait cycles, then decode (op must already be set).
    task automatic fetch_decode(input int fs, input logic z, input logic nm_rdy, input logic ill);
        for (int i = 0; i < fs; i++)
            cyc(0, z, 1, mk(0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b10, 2'b00, 0), 1);
        cyc(1, z, 1, mk(0, 1, 0, 0, 1, 1, 0, 2'b00, 2'b10, 2'b10, 2'b00, 0), 1);
        cyc(nm_rdy, z, 1, mk(1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 2'b00, ill), 1);
    endtask

    task automatic aluwb(input logic z, input logic nm_rdy);
        cyc(nm_rdy, z, 1, mk(8, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0), 1);
    endtask

    // Whole instruction: fs fetch waits, ms memory-access waits.
    task automatic run_instr(input logic [6:0] o, input logic z, input int fs, input int ms, input logic nm_rdy);
        logic legal;
        op = o;
        legal = (o == 7'b0000011) || (o == 7'b0100011) || (o == 7'b0110011) ||
                (o == 7'b0010011) || (o == 7'b1100011);
`ifdef MULTICYCLE_JAL_EN
        if (o == 7'b1101111) legal = 1'b1;
`endif
        fetch_decode(fs, z, nm_rdy, ~legal);
        if (legal) begin
            case (o)
                7'b0000011: begin
                    cyc(nm_rdy, z, 1, mk(2, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b00, 0), 1);
                    for (int i = 0; i <= ms; i++)
                        cyc((i == ms), z, 1, mk(3, 1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0), 1);
                    cyc(nm_rdy, z, 1, mk(4, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b01, 2'b00, 0), 1);
                end
                7'b0100011: begin
                    cyc(nm_rdy, z, 1, mk(2, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b00, 0), 1);
                    for (int i = 0; i <= ms; i++)
                        cyc((i == ms), z, 1, mk(5, 1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0), 1);
                end
                7'b0110011: begin
                    cyc(nm_rdy, z, 1, mk(6, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 2'b10, 0), 1);
                    aluwb(z, nm_rdy);
                end
                7'b0010011: begin
                    cyc(nm_rdy, z, 1, mk(7, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b10, 0), 1);
                    aluwb(z, nm_rdy);
                end
                7'b1100011:
                    cyc(nm_rdy, z, 1, mk(9, 0, 0, 0, 0, z, 0, 2'b10, 2'b00, 2'b00, 2'b01, 0), 1);
                default: begin
                    // jal (only legal when the option is built in)
                    cyc(nm_rdy, z, 1, mk(10, 0, 0, 0, 0, 1, 0, 2'b01, 2'b10, 2'b00, 2'b00, 0), 1);
                    aluwb(z, nm_rdy);
                end
            endcase
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        @(posedge clk);
        #1;
        // Power-up reset; first cycle state is still unknown
        cyc(1, 0, 0, e_reset(0), 0);
        cyc(1, 0, 0, e_reset(0), 1);

        clear_log;
        run_instr(7'b0110011, 0, 0, 0, 1);
        check_log("rtype_seq", 64'h0168, 4);

        clear_log;
        run_instr(7'b0010011, 1, 0, 0, 0);
        check_log("itype_seq", 64'h0178, 4);

        clear_log;
        run_instr(7'b0000011, 0, 0, 2, 1);
        check_log("lw_stall_seq", 64'h0123334, 7);

        clear_log;
        run_instr(7'b0000011, 0, 0, 0, 0);
        check_log("lw_seq", 64'h01234, 5);

        clear_log;
        run_instr(7'b0100011, 0, 0, 0, 1);
        check_log("sw_seq", 64'h0125, 4);

        clear_log;
        run_instr(7'b0100011, 1, 1, 1, 1);
        check_log("sw_stall_seq", 64'h000125_5, 6);

        clear_log;
        run_instr(7'b1100011, 1, 0, 0, 1);
        check_log("beq_taken_seq", 64'h019, 3);
        clear_log;
        run_instr(7'b1100011, 0, 0, 0, 0);
        check_log("beq_not_taken_seq", 64'h019, 3);

        clear_log;
        run_instr(7'b1101111, 0, 0, 0, 1);
`ifdef MULTICYCLE_JAL_EN
        check_log("jal_seq", 64'h01A8, 4);
        check_ill("jal_ill", 0);
`else
        check_log("jal_seq", 64'h01, 2);
        check_ill("jal_ill", 1);
`endif

        clear_log;
        run_instr(7'b1110011, 0, 0, 0, 1);
        check_log("illegal_seq", 64'h01, 2);
        check_ill("illegal_ill", 1);

        // Reset in the middle of a load's MEMREAD stall
        op = 7'b0000011;
        fetch_decode(0, 0, 1, 0);
        cyc(1, 0, 1, mk(2, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b00, 0), 1);
        cyc(0, 0, 1, mk(3, 1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0), 1);
        clear_log;
        cyc(0, 0, 0, e_reset(3), 1);
        cyc(1, 0, 0, e_reset(0), 1);
        check_log("reset_seq", 64'h30, 2);
        clear_log;
        run_instr(7'b0110011, 0, 0, 0, 1);
        check_log("post_reset_seq", 64'h0168, 4);

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multicycle_fsm.md
# multicycle_fsm

Main control state machine for the multicycle RV32I core variant. Sequences instruction fetch, decode, execute, memory access and write-back over several clock cycles, reusing the single ALU, register file and unified memory port. Drives the 2-bit `alu_op` class consumed by the ALU decoder, plus all datapath mux selects and write enables. Supports lw, sw, R-type, I-type ALU, beq and (optionally) jal, and stalls on a memory ready handshake.

## Interface
- No parameters.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `op`  in  7  opcode from instruction register; valid from DECODE onward.
- `zero`  in  1  ALU zero flag.
- `mem_ready`  in  1  memory completes the current access this cycle.
- `mem_req`  out  1  memory access request.
- `mem_write`  out  1  access is a store; qualified by `mem_req`.
- `adr_src`  out  1  memory address: 0 = PC, 1 = ALUOut.
- `ir_write`  out  1  load instruction register and OldPC.
- `pc_write`  out  1  load PC from result bus.
- `reg_write`  out  1  register file write enable.
- `alu_src_a`  out  2  00 = PC, 01 = OldPC, 10 = rs1 data.
- `alu_src_b`  out  2  00 = rs2 data, 01 = immediate, 10 = constant 4.
- `result_src`  out  2  00 = ALUOut, 01 = memory data, 10 = ALU result.
- `alu_op`  out  2  00 = add, 01 = subtract, 10 = funct-decoded.
- `illegal_instr`  out  1  one-cycle pulse: unsupported opcode.
- `state`  out  4  current state, debug only.

## Operation
- State register only; outputs decoded combinationally from state (`pc_write` in BEQ and write enables in FETCH also use inputs). Unlisted outputs are 0 in each state.
- Encoding: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, EXECUTEI 7, ALUWB 8, BEQ 9, JAL 10.
- FETCH: mem_req=1, adr_src=0, src_a=00, src_b=10, alu_op=00, result_src=10. ir_write=pc_write=mem_ready. Next: DECODE if mem_ready, else FETCH.
- DECODE: src_a=01, src_b=01, alu_op=00 (branch target into ALUOut). Next on `op`: 0000011/0100011 -> MEMADR; 0110011 -> EXECUTER; 0010011 -> EXECUTEI; 1100011 -> BEQ; 1101111 -> JAL (if enabled); other -> FETCH with illegal_instr=1 this cycle.
- MEMADR: src_a=10, src_b=01, alu_op=00. Next: MEMREAD if op[5]=0, MEMWRITE if op[5]=1.
- MEMREAD: mem_req=1, adr_src=1, result_src=00. Next: MEMWB on mem_ready, else hold.
- MEMWB: result_src=01, reg_write=1 -> FETCH.
- MEMWRITE: mem_req=1, mem_write=1, adr_src=1, result_src=00. Next: FETCH on mem_ready, else hold.
- EXECUTER: src_a=10, src_b=00, alu_op=10 -> ALUWB. EXECUTEI: src_a=10, src_b=01, alu_op=10 -> ALUWB.
- ALUWB: result_src=00, reg_write=1 -> FETCH.
- BEQ: src_a=10, src_b=00, alu_op=01, result_src=00, pc_write=zero -> FETCH.
- JAL: src_a=01, src_b=10, alu_op=00, result_src=00, pc_write=1 -> ALUWB.
- Unused encodings 11-15: all outputs 0, next FETCH.

## Timing
- Reset: rst_n sampled low -> state=FETCH next edge. While rst_n low, mem_req, mem_write, ir_write, pc_write, reg_write, illegal_instr forced 0; other outputs carry FETCH values. Reset mid-instruction, including mid-stall, abandons it; no write enable asserts after the reset edge until FETCH completes.
- Cycles with mem_ready held 1: lw 5, sw 4, R/I-type 4, beq 3, jal 4. Each cycle mem_ready=0 in FETCH/MEMREAD/MEMWRITE adds one cycle.
- Handshake: mem_req, adr_src, mem_write stable while stalled; access completes in the cycle mem_ready=1 with mem_req=1. mem_ready ignored when mem_req=0.
- `illegal_instr` is high only in the DECODE cycle; the next state is FETCH.

## Configuration
- `MULTICYCLE_JAL_EN` defined: JAL state and the 1101111 decode are present.
- Not defined: state 10 is unused (treated as an unused encoding), and 1101111 decodes as illegal.

## Test plan
- Reset: rst_n=0 for 2 cycles during MEMREAD stall -> state=0, all write enables 0; first edge with rst_n=1 and mem_ready=1 -> ir_write=pc_write=1, then state=1.
- R-type: op=0110011, mem_ready=1 -> states 0,1,6,8,0; alu_op=10 in state 6; reg_write=1 only in state 8.
- lw with 2 wait cycles in MEMREAD: op=0000011 -> 0,1,2,3,3,3,4,0; mem_req=1, adr_src=1 held for all three MEMREAD cycles; reg_write with result_src=01 in state 4.
- beq: op=1100011 with zero=1 -> pc_write=1 in state 9; repeat with zero=0 -> pc_write=0; alu_op=01 in both.
- jal: op=1101111 -> 0,1,10,8,0 with macro defined; with macro undefined -> 0,1,0 and illegal_instr pulses once in the DECODE cycle.
- Unsupported op=1110011 -> illegal_instr=1 for exactly one cycle, no reg_write/mem_write, returns to FETCH.
